// File: rtl/spi_pkg.sv
// Shared types and lane mapping for the SPI receive word packer.
package spi_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned ENTRY_BITS = 35;

  typedef logic [1:0] laneIdx_t;
  typedef logic [2:0] byteCnt_t;

  // Byte-count encoding: plain binary 1..4; 0 only appears on an empty FIFO.
  localparam byteCnt_t BYTES_FULL = 3'd4;

  typedef struct packed {
    logic [31:0] data;
    byteCnt_t    bytes;
  } wordEntry_t;

  // Lane 0 is the first byte of a word and lands in bits 31:24 (big-endian).
  function automatic logic [31:0] placeLane(input logic [31:0] word, input laneIdx_t lane,
                                            input logic [7:0] b);
    logic [31:0] r;
    r = word;
    unique case (lane)
      2'd0: r[31:24] = b;
      2'd1: r[23:16] = b;
      2'd2: r[15:8]  = b;
      2'd3: r[7:0]   = b;
      default: r = word;
    endcase
    return r;
  endfunction

  // Byte count of a partial word holding lanes 0..n-1.
  function automatic byteCnt_t encodePartial(input laneIdx_t n);
    return {1'b0, n};
  endfunction

endpackage

// File: rtl/spi_word_fifo.sv
// First-word-fall-through FIFO of packed words (32-bit data + byte count).
module spi_word_fifo
  import spi_pkg::*;
#(
  parameter int unsigned DepthLog2 = 3
) (
  input  logic                 SysClk,
  input  logic                 Reset,
  input  logic                 push,
  input  wordEntry_t           wrEntry,
  input  logic                 pop,
  output wordEntry_t           rdEntry,
  output logic                 full,
  output logic                 empty,
  output logic [DepthLog2:0]   count
);

  localparam int unsigned Depth = 1 << DepthLog2;

  typedef logic [DepthLog2-1:0] ptr_t;
  typedef logic [DepthLog2:0]   cnt_t;

  wordEntry_t mem [Depth];
  ptr_t       wrPtrQ, rdPtrQ;
  cnt_t       countQ;
  logic       doPush, doPop;

  assign empty = (countQ == cnt_t'(0));
  assign full  = (countQ == cnt_t'(Depth));
  assign count = countQ;

  // A pop frees a slot in the same cycle, so a push into a full FIFO with a pop is taken.
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);

  // Head is presented straight from storage; forced to zero when empty.
  assign rdEntry = empty ? '0 : mem[rdPtrQ];

  // Storage write; no reset needed since reads are gated by empty.
  always_ff @(posedge SysClk) begin
    if (doPush) mem[wrPtrQ] <= wrEntry;
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge SysClk) begin
    if (Reset) begin
      wrPtrQ <= '0;
      rdPtrQ <= '0;
      countQ <= '0;
    end else begin
      if (doPush) wrPtrQ <= wrPtrQ + ptr_t'(1);
      if (doPop)  rdPtrQ <= rdPtrQ + ptr_t'(1);
      if (doPush && !doPop)      countQ <= countQ + cnt_t'(1);
      else if (doPop && !doPush) countQ <= countQ - cnt_t'(1);
    end
  end

endmodule

// File: rtl/spi_rx_packer.sv
// Packs received SPI bytes into big-endian 32-bit words and queues them in a FIFO.
module spi_rx_packer
  import spi_pkg::*;
#(
  parameter int unsigned AddrBits      = 12,
  parameter int unsigned FifoDepthLog2 = 3
) (
  input  logic                     SysClk,
  input  logic                     Reset,
  input  logic [AddrBits-1:0]      rcMemAddr,
  input  logic [7:0]               rcMemData,
  input  logic                     rcMemWE,
  input  logic                     flushReq,
  output logic [31:0]              wordData,
  output logic [2:0]               wordBytes,
  output logic                     wordValid,
  input  logic                     wordReady,
  output logic [FifoDepthLog2:0]   fifoCount,
  output logic                     overflow
);

  logic [31:0] shiftQ, shiftD;
  laneIdx_t    laneCntQ, laneCntD;
  logic        overflowQ;
  logic        pushReq;
  wordEntry_t  pushEntry;
  wordEntry_t  headEntry;
  logic        fifoFull, fifoEmpty;
  logic        newPacket;
  logic [31:0] filled;

  // Address 0 with a pending partial word: the partial word owns the push slot.
  assign newPacket = rcMemWE && (rcMemAddr == '0) && (laneCntQ != 2'd0);
  assign filled    = placeLane(shiftQ, laneCntQ, rcMemData);

  // Assembler next state and push arbitration.
  always_comb begin
    shiftD    = shiftQ;
    laneCntD  = laneCntQ;
    pushReq   = 1'b0;
    pushEntry = '0;
    if (newPacket) begin
      pushReq   = 1'b1;
      pushEntry = '{data: shiftQ, bytes: encodePartial(laneCntQ)};
      shiftD    = placeLane(32'd0, 2'd0, rcMemData);
      laneCntD  = 2'd1;
    end else if (rcMemWE) begin
      // With laneCnt 0 an address-0 byte lands in lane 0 like any other byte.
      if (laneCntQ == 2'd3) begin
        pushReq   = 1'b1;
        pushEntry = '{data: filled, bytes: BYTES_FULL};
        shiftD    = '0;
        laneCntD  = 2'd0;
      end else if (flushReq) begin
        pushReq   = 1'b1;
        pushEntry = '{data: filled, bytes: encodePartial(laneCntQ + 2'd1)};
        shiftD    = '0;
        laneCntD  = 2'd0;
      end else begin
        shiftD   = filled;
        laneCntD = laneCntQ + 2'd1;
      end
    end else if (flushReq && (laneCntQ != 2'd0)) begin
      pushReq   = 1'b1;
      pushEntry = '{data: shiftQ, bytes: encodePartial(laneCntQ)};
      shiftD    = '0;
      laneCntD  = 2'd0;
    end
  end

  // Assembler state and sticky overflow flag.
  always_ff @(posedge SysClk) begin
    if (Reset) begin
      shiftQ    <= '0;
      laneCntQ  <= '0;
      overflowQ <= 1'b0;
    end else begin
      shiftQ   <= shiftD;
      laneCntQ <= laneCntD;
      if (pushReq && fifoFull && !(wordReady && !fifoEmpty)) overflowQ <= 1'b1;
    end
  end

  spi_word_fifo #(
    .DepthLog2 (FifoDepthLog2)
  ) uFifo (
    .SysClk  (SysClk),
    .Reset   (Reset),
    .push    (pushReq),
    .wrEntry (pushEntry),
    .pop     (wordReady),
    .rdEntry (headEntry),
    .full    (fifoFull),
    .empty   (fifoEmpty),
    .count   (fifoCount)
  );

  assign wordData  = headEntry.data;
  assign wordBytes = headEntry.bytes;
  assign wordValid = !fifoEmpty;
  assign overflow  = overflowQ;

endmodule

// File: tb/tb_spi_rx_packer.sv
// Directed bench for spi_rx_packer: vector table plus multi-cycle FIFO/reset sequences.
module tb_spi_rx_packer;

  logic        SysClk;
  logic        Reset;
  logic [11:0] rcMemAddr;
  logic [7:0]  rcMemData;
  logic        rcMemWE;
  logic        flushReq;
  logic [31:0] wordData;
  logic [2:0]  wordBytes;
  logic        wordValid;
  logic        wordReady;
  logic [3:0]  fifoCount;
  logic        overflow;

  int checks   = 0;
  int failures = 0;

  spi_rx_packer #(
    .AddrBits      (12),
    .FifoDepthLog2 (3)
  ) dut (
    .SysClk    (SysClk),
    .Reset     (Reset),
    .rcMemAddr (rcMemAddr),
    .rcMemData (rcMemData),
    .rcMemWE   (rcMemWE),
    .flushReq  (flushReq),
    .wordData  (wordData),
    .wordBytes (wordBytes),
    .wordValid (wordValid),
    .wordReady (wordReady),
    .fifoCount (fifoCount),
    .overflow  (overflow)
  );

  initial SysClk = 1'b0;
  always #5 SysClk = ~SysClk;

  typedef struct {
    logic        we;
    logic [11:0] addr;
    logic [7:0]  data;
    logic        flush;
    logic        ready;
    logic        expValid;
    logic [31:0] expData;
    logic [2:0]  expBytes;
    logic [3:0]  expCount;
    logic        expOvf;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  task automatic checkOut(input string tag, input logic v, input logic [31:0] d,
                          input logic [2:0] b, input logic [3:0] c, input logic o);
    check({tag, ".valid"}, 32'(wordValid), 32'(v));
    check({tag, ".data"}, wordData, d);
    check({tag, ".bytes"}, 32'(wordBytes), 32'(b));
    check({tag, ".count"}, 32'(fifoCount), 32'(c));
    check({tag, ".ovf"}, 32'(overflow), 32'(o));
  endtask

  // One clock with the given inputs; returns 1ns after the edge with inputs idle.
  task automatic step(input logic we, input logic [11:0] addr, input logic [7:0] data,
                      input logic flush, input logic ready);
    rcMemWE   = we;
    rcMemAddr = addr;
    rcMemData = data;
    flushReq  = flush;
    wordReady = ready;
    @(posedge SysClk);
    #1;
    rcMemWE   = 1'b0;
    rcMemAddr = '0;
    rcMemData = '0;
    flushReq  = 1'b0;
    wordReady = 1'b0;
  endtask

  function automatic logic [31:0] seqWord(input int i);
    return {8'(8'h10 + i), 8'(8'h20 + i), 8'(8'h30 + i), 8'(8'h40 + i)};
  endfunction

  task automatic pushWord(input int i);
    logic [31:0] w;
    w = seqWord(i);
    step(1'b1, 12'd1, w[31:24], 1'b0, 1'b0);
    step(1'b1, 12'd2, w[23:16], 1'b0, 1'b0);
    step(1'b1, 12'd3, w[15:8], 1'b0, 1'b0);
    step(1'b1, 12'd4, w[7:0], 1'b0, 1'b0);
  endtask

  initial begin
    Reset = 1'b1;
    rcMemWE = 1'b0; rcMemAddr = '0; rcMemData = '0; flushReq = 1'b0; wordReady = 1'b0;
    step(1'b0, 12'd0, 8'h00, 1'b0, 1'b0);
    // Inputs while in reset must be ignored.
    step(1'b1, 12'd1, 8'h99, 1'b1, 1'b1);
    checkOut("reset", 1'b0, 32'h0, 3'd0, 4'd0, 1'b0);
    Reset = 1'b0;

    // we addr data flush ready | valid data bytes count ovf
    vq.push_back('{1'b1, 12'd1, 8'h11, 1'b0, 1'b0, 1'b0, 32'h0, 3'd0, 4'd0, 1'b0});
    vq.push_back('{1'b1, 12'd2, 8'h22, 1'b0, 1'b0, 1'b0, 32'h0, 3'd0, 4'd0, 1'b0});
    vq.push_back('{1'b1, 12'd3, 8'h33, 1'b0, 1'b0, 1'b0, 32'h0, 3'd0, 4'd0, 1'b0});
    vq.push_back('{1'b1, 12'd4, 8'h44, 1'b0, 1'b0, 1'b1, 32'h11223344, 3'd4, 4'd1, 1'b0});
    vq.push_back('{1'b0, 12'd0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0, 3'd0, 4'd0, 1'b0});
    vq.push_back('{1'b1, 12'd1, 8'hAA, 1'b0, 1'b0, 1'b0, 32'h0, 3'd0, 4'd0, 1'b0});
    vq.push_back('{1'b1, 12'd2, 8'hBB, 1'b0, 1'b0, 1'b0, 32'h0, 3'd0, 4'd0, 1'b0});
    vq.push_back('{1'b1, 12'd0, 8'hCC, 1'b0, 1'b0, 1'b1, 32'hAABB0000, 3'd2, 4'd1, 1'b0});
    vq.push_back('{1'b0, 12'd0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0, 3'd0, 4'd0, 1'b0});
    vq.push_back('{1'b0, 12'd0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0, 3'd0, 4'd0, 1'b0});
    vq.push_back('{1'b0, 12'd0, 8'h00, 1'b1, 1'b0, 1'b1, 32'hCC000000, 3'd1, 4'd1, 1'b0});
    vq.push_back('{1'b0, 12'd0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0, 3'd0, 4'd0, 1'b0});
    vq.push_back('{1'b0, 12'd0, 8'h00, 1'b1, 1'b0, 1'b0, 32'h0, 3'd0, 4'd0, 1'b0});
    vq.push_back('{1'b1, 12'd5, 8'hDD, 1'b0, 1'b0, 1'b0, 32'h0, 3'd0, 4'd0, 1'b0});
    vq.push_back('{1'b1, 12'd6, 8'hEE, 1'b1, 1'b0, 1'b1, 32'hDDEE0000, 3'd2, 4'd1, 1'b0});
    vq.push_back('{1'b0, 12'd0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0, 3'd0, 4'd0, 1'b0});
    vq.push_back('{1'b1, 12'd1, 8'h01, 1'b0, 1'b0, 1'b0, 32'h0, 3'd0, 4'd0, 1'b0});
    vq.push_back('{1'b1, 12'd2, 8'h02, 1'b0, 1'b0, 1'b0, 32'h0, 3'd0, 4'd0, 1'b0});
    vq.push_back('{1'b1, 12'd3, 8'h03, 1'b0, 1'b0, 1'b0, 32'h0, 3'd0, 4'd0, 1'b0});
    vq.push_back('{1'b1, 12'd4, 8'h04, 1'b1, 1'b0, 1'b1, 32'h01020304, 3'd4, 4'd1, 1'b0});
    vq.push_back('{1'b0, 12'd0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0, 3'd0, 4'd0, 1'b0});
    vq.push_back('{1'b1, 12'd0, 8'h77, 1'b1, 1'b0, 1'b1, 32'h77000000, 3'd1, 4'd1, 1'b0});
    vq.push_back('{1'b1, 12'd1, 8'h55, 1'b0, 1'b1, 1'b0, 32'h0, 3'd0, 4'd0, 1'b0});
    vq.push_back('{1'b0, 12'd0, 8'h00, 1'b1, 1'b0, 1'b1, 32'h55000000, 3'd1, 4'd1, 1'b0});
    vq.push_back('{1'b0, 12'd0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0, 3'd0, 4'd0, 1'b0});

    foreach (vq[i]) begin
      step(vq[i].we, vq[i].addr, vq[i].data, vq[i].flush, vq[i].ready);
      checkOut($sformatf("v%0d", i), vq[i].expValid, vq[i].expData, vq[i].expBytes,
               vq[i].expCount, vq[i].expOvf);
    end

    // Nine full words with no consumer: ninth is dropped, first eight kept in order.
    for (int i = 0; i < 9; i++) pushWord(i);
    check("ovfFill.count", 32'(fifoCount), 32'd8);
    check("ovfFill.ovf", 32'(overflow), 32'd1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("ovfDrain%0d.data", i), wordData, seqWord(i));
      check($sformatf("ovfDrain%0d.bytes", i), 32'(wordBytes), 32'd4);
      step(1'b0, 12'd0, 8'h00, 1'b0, 1'b1);
    end
    checkOut("ovfEmpty", 1'b0, 32'h0, 3'd0, 4'd0, 1'b1);

    // Reset with three words queued and a half-built word.
    for (int i = 20; i < 23; i++) pushWord(i);
    step(1'b1, 12'd1, 8'hE1, 1'b0, 1'b0);
    step(1'b1, 12'd2, 8'hE2, 1'b0, 1'b0);
    check("preReset.count", 32'(fifoCount), 32'd3);
    Reset = 1'b1;
    step(1'b1, 12'd3, 8'hE3, 1'b1, 1'b0);
    checkOut("midReset", 1'b0, 32'h0, 3'd0, 4'd0, 1'b0);
    Reset = 1'b0;
    pushWord(30);
    checkOut("postReset", 1'b1, seqWord(30), 3'd4, 4'd1, 1'b0);
    step(1'b0, 12'd0, 8'h00, 1'b0, 1'b1);

    // Full FIFO, then push and pop on the same edge.
    for (int i = 0; i < 8; i++) pushWord(i);
    check("full.count", 32'(fifoCount), 32'd8);
    step(1'b1, 12'd1, 8'h50, 1'b0, 1'b0);
    step(1'b1, 12'd2, 8'h60, 1'b0, 1'b0);
    step(1'b1, 12'd3, 8'h70, 1'b0, 1'b0);
    step(1'b1, 12'd4, 8'h80, 1'b0, 1'b1);
    check("pushPop.count", 32'(fifoCount), 32'd8);
    check("pushPop.ovf", 32'(overflow), 32'd0);
    for (int i = 1; i < 8; i++) begin
      check($sformatf("ppDrain%0d.data", i), wordData, seqWord(i));
      step(1'b0, 12'd0, 8'h00, 1'b0, 1'b1);
    end
    check("ppLast.data", wordData, 32'h50607080);
    check("ppLast.bytes", 32'(wordBytes), 32'd4);
    step(1'b0, 12'd0, 8'h00, 1'b0, 1'b1);
    checkOut("ppEmpty", 1'b0, 32'h0, 3'd0, 4'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_rx_packer.md
SPI_RX_PACKER -- requirements
Module: spi_rx_packer

Interface
REQ-001 Parameter AddrBits, default 12: width of rcMemAddr; matches the SPI interface byte-buffer address.
REQ-002 Parameter FifoDepthLog2, default 3: log2 of the output word FIFO depth (8 entries).
REQ-003 SysClk  in  1  system clock; all logic is on the rising edge.
REQ-004 Reset  in  1  synchronous, active-high reset.
REQ-005 rcMemAddr  in  AddrBits  byte address from the SPI interface receive path.
REQ-006 rcMemData  in  8  received byte.
REQ-007 rcMemWE  in  1  single-cycle strobe; the byte is valid this cycle.
REQ-008 flushReq  in  1  single-cycle pulse; push any partial word.
REQ-009 wordData  out  32  FIFO head word, big-endian: the first byte is in bits 31:24.
REQ-010 wordBytes  out  3  number of valid bytes in wordData (1-4).
REQ-011 wordValid  out  1  FIFO not empty.
REQ-012 wordReady  in  1  consumer accepts the head word when wordValid and wordReady are both high.
REQ-013 fifoCount  out  FifoDepthLog2+1  current FIFO occupancy.
REQ-014 overflow  out  1  sticky: a word was dropped because the FIFO was full.

Function
REQ-015 The assembler SHALL hold a 32-bit shift word plus a byte count, laneCnt, ranging 0-3.
REQ-016 When rcMemWE=1 and rcMemAddr!=0, rcMemData SHALL go to lane laneCnt (lane 0 = bits 31:24), and laneCnt SHALL increment.
REQ-017 When a write fills lane 3, the word SHALL be pushed with wordBytes=4, and laneCnt SHALL return to 0.
REQ-018 When rcMemWE=1 and rcMemAddr==0 (new packet), the pending partial word (laneCnt>0) SHALL be pushed first with wordBytes=laneCnt, and the new byte SHALL go to lane 0 in the same cycle.
REQ-019 A flushReq with laneCnt>0 SHALL push the partial word and clear laneCnt.
REQ-020 A flushReq with laneCnt==0 SHALL do nothing.
REQ-021 If flushReq and rcMemWE occur in the same cycle, the incoming byte SHALL be included first, then the resulting partial word SHALL be pushed.
REQ-022 If that cycle's byte itself completes a word, exactly one push SHALL occur.
REQ-023 In a pushed partial word, unused lanes SHALL be zero.
REQ-024 At most one push per cycle, except the REQ-018 case. There, the partial push takes the single push slot, and the new byte stays in the assembler.
REQ-025 The FIFO SHALL be first-word-fall-through: wordData and wordBytes come from head registers.
REQ-026 When the FIFO is empty, a push at edge N SHALL make wordValid=1 after edge N (1-cycle latency).
REQ-027 A pop SHALL occur when wordValid and wordReady are both high; the head SHALL advance at that edge.
REQ-028 A push when full with no simultaneous pop SHALL drop the word and set overflow=1 until Reset.
REQ-029 A push when full with a simultaneous pop SHALL be accepted, and fifoCount SHALL stay unchanged.
REQ-030 Pointers SHALL wrap modulo 2^FifoDepthLog2. fifoCount SHALL never exceed 2^FifoDepthLog2.
REQ-031 wordReady while empty SHALL be ignored.

Reset
REQ-032 While Reset=1: laneCnt=0, shift word=0, FIFO empty, fifoCount=0, wordValid=0, wordData=0, wordBytes=0, overflow=0.
REQ-033 Reset SHALL discard any partial word and FIFO contents without pushing them, including mid-word and mid-packet.
REQ-034 Inputs SHALL be ignored in a cycle where Reset=1.

Structure
REQ-035 A shared package spi_pkg SHALL hold WORD_BYTES=4, the lane-to-bit-range mapping, and the wordBytes encoding.
REQ-036 The FIFO SHALL be a separate sub-module, spi_word_fifo: 35-bit entries (data plus byte count), parameterised depth, push/pop/full/empty/count.
REQ-037 The assembler and push arbitration SHALL live in spi_rx_packer.

Verification
REQ-038 Bytes 11,22,33,44 written at addresses 1-4 -> one word 0x11223344, wordBytes=4, wordValid high one cycle after the 4th write.
REQ-039 Bytes AA,BB at addresses 1,2, then byte CC at address 0 -> word 0xAABB0000 with wordBytes=2; a later flushReq -> 0xCC000000 with wordBytes=1.
REQ-040 wordReady=0 while 9 full words are pushed -> fifoCount=8, overflow=1, first 8 words intact in order.
REQ-041 FIFO full, then push and pop in the same cycle -> fifoCount stays 8, overflow stays 0, new word appears last.
REQ-042 Reset asserted after 2 bytes of a word with 3 words queued -> wordValid=0, fifoCount=0. A subsequent 4-byte sequence yields a correct word.
REQ-043 flushReq together with a byte write into lane 1 -> a single push with wordBytes=2.
